lanes_serializer_mc: RTL and testbench

- Parametrised multi-lane parallel-to-serial converter for the USB4 transmit lane path.
- Sits between the per-lane encoders and the scrambler/line stage.
- Generalises the fixed 2-lane serializer with:
  - NUM_LANES lanes;
  - per-generation symbol lengths set by parameters;
  - valid/ready input handshake with a one-word holding buffer;
  - per-lane enable mask;
  - explicit underrun signalling.
- Provides the symbol-start pulse that reseeds the downstream scrambler.

---
 rtl/lanes_serializer_mc.sv | 187 ++++++++++++++++++
 tb/tb_lanes_serializer_mc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lanes_serializer_mc.sv
// rtl/lanes_serializer_mc.sv - multi-lane parallel-to-serial converter for the USB4 TX lane path
// Ports: clk, rst (async, active-low), enable, gen_speed, lane_en,
//        in_data/in_valid/in_ready (word handshake, one-word holding buffer),
//        lane_tx (one serial bit per lane), sym_start (first bit of each symbol,
//        reseeds the scrambler), underrun (first bit of a zero-fill symbol),
//        tx_active (state RUN).
// Optional: define LANES_SERIALIZER_MC_UNDERRUN_CNT_EN to add underrun_cnt[15:0],
//        a saturating count of zero-fill symbols cleared only by rst.
module lanes_serializer_mc #(
    parameter int NUM_LANES = 2,
    parameter int DATA_W    = 132,
    parameter int SYM_LEN_0 = 8,
    parameter int SYM_LEN_1 = 132,
    parameter int SYM_LEN_2 = 66
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [1:0]                  gen_speed,
    input  logic [NUM_LANES-1:0]        lane_en,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [NUM_LANES-1:0]        lane_tx,
    output logic                        sym_start,
    output logic                        underrun,
`ifdef LANES_SERIALIZER_MC_UNDERRUN_CNT_EN
    output logic [15:0]                 underrun_cnt,
`endif
    output logic                        tx_active
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WW = NUM_LANES * DATA_W;

    typedef enum logic [1:0] {ST_OFF, ST_WAIT, ST_RUN} state_t;
    state_t state;

    logic [CW-1:0]        cnt;
    logic [CW-1:0]        sym_len;
    logic                 msb_first;
    logic [NUM_LANES-1:0] lane_en_q;
    logic [WW-1:0]        shreg;
    logic [WW-1:0]        buf_data;
    logic                 buf_valid;

    logic                 boundary;
    logic                 accept;
    logic                 load;
    logic                 load_zero;
    logic [WW-1:0]        load_word;
    logic [WW-1:0]        shreg_nxt;
    logic [NUM_LANES-1:0] tx_nxt;
    logic [CW-1:0]        new_len;
    logic                 new_msb;
    logic [CW-1:0]        cur_len;
    logic                 cur_msb;
    logic [NUM_LANES-1:0] cur_en;
    logic [DATA_W-1:0]    src;
    logic [IW-1:0]        top_idx;

    // Reserved code 11 falls through to the 00 length and bit order.
    always_comb begin
        case (gen_speed)
            2'b01:   new_len = CW'(SYM_LEN_1);
            2'b10:   new_len = CW'(SYM_LEN_2);
            default: new_len = CW'(SYM_LEN_0);
        endcase
    end
    assign new_msb = ~(gen_speed[1] ^ gen_speed[0]);

    assign boundary = (state == ST_RUN) && (cnt == sym_len - CW'(1));
    assign in_ready = enable && (state != ST_OFF) &&
                      (!buf_valid || boundary || (state == ST_WAIT));
    assign accept   = in_valid && in_ready;

    // Load source priority at a boundary: buffered word, then bypass, then zeros.
    always_comb begin
        load      = 1'b0;
        load_zero = 1'b0;
        load_word = '0;
        if (enable && (state == ST_WAIT) && accept) begin
            load      = 1'b1;
            load_word = in_data;
        end else if (enable && boundary) begin
            load = 1'b1;
            if (buf_valid) begin
                load_word = buf_data;
            end else if (accept) begin
                load_word = in_data;
            end else begin
                load_zero = 1'b1;
            end
        end
    end

    // On a load edge the first bit goes straight to lane_tx and the shift
    // register keeps the remainder, so the symbol starts one cycle after the load.
    always_comb begin
        cur_len   = load ? new_len : sym_len;
        cur_msb   = load ? new_msb : msb_first;
        cur_en    = load ? lane_en : lane_en_q;
        top_idx   = IW'(cur_len - CW'(1));
        shreg_nxt = '0;
        tx_nxt    = '0;
        src       = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            src = load ? load_word[i*DATA_W +: DATA_W] : shreg[i*DATA_W +: DATA_W];
            if (cur_msb) begin
                tx_nxt[i]                     = cur_en[i] & src[top_idx];
                shreg_nxt[i*DATA_W +: DATA_W] = src << 1;
            end else begin
                tx_nxt[i]                     = cur_en[i] & src[0];
                shreg_nxt[i*DATA_W +: DATA_W] = src >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_OFF;
            cnt       <= '0;
            sym_len   <= '0;
            msb_first <= 1'b0;
            lane_en_q <= '0;
            shreg     <= '0;
            buf_data  <= '0;
            buf_valid <= 1'b0;
            lane_tx   <= '0;
            sym_start <= 1'b0;
            underrun  <= 1'b0;
            tx_active <= 1'b0;
        end else if (!enable) begin
            state     <= ST_OFF;
            cnt       <= '0;
            shreg     <= '0;
            buf_data  <= '0;
            buf_valid <= 1'b0;
            lane_tx   <= '0;
            sym_start <= 1'b0;
            underrun  <= 1'b0;
            tx_active <= 1'b0;
        end else begin
            case (state)
                ST_OFF: state <= ST_WAIT;
                ST_WAIT, ST_RUN: begin
                    if (load || (state == ST_RUN)) begin
                        state     <= ST_RUN;
                        tx_active <= 1'b1;
                        shreg     <= shreg_nxt;
                        lane_tx   <= tx_nxt;
                        sym_start <= load;
                        underrun  <= load_zero;
                        cnt       <= load ? '0 : cnt + CW'(1);
                        if (load) begin
                            sym_len   <= new_len;
                            msb_first <= new_msb;
                            lane_en_q <= lane_en;
                        end
                        // Pop and refill in the same edge keeps exactly one word queued.
                        if (boundary) begin
                            if (buf_valid) begin
                                buf_valid <= accept;
                                if (accept) buf_data <= in_data;
                            end
                        end else if ((state == ST_RUN) && accept) begin
                            buf_valid <= 1'b1;
                            buf_data  <= in_data;
                        end
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

`ifdef LANES_SERIALIZER_MC_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_cnt <= '0;
        end else if (load_zero && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lanes_serializer_mc.sv
// tb/tb_lanes_serializer_mc.sv - scoreboard bench for lanes_serializer_mc
module tb_lanes_serializer_mc;
    localparam int NL = 2;
    localparam int DW = 132;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enable = 1'b0;
    logic [1:0]      gen_speed = 2'b00;
    logic [NL-1:0]   lane_en = 2'b11;
    logic [NL*DW-1:0] in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [NL-1:0]   lane_tx;
    logic            sym_start;
    logic            underrun;
    logic            tx_active;
`ifdef LANES_SERIALIZER_MC_UNDERRUN_CNT_EN
    logic [15:0]     underrun_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ucnt = 0;
    logic [NL+1:0] exp_q[$];

    always #5 clk = ~clk;

    lanes_serializer_mc #(
        .NUM_LANES(NL), .DATA_W(DW), .SYM_LEN_0(8), .SYM_LEN_1(132), .SYM_LEN_2(66)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .gen_speed(gen_speed), .lane_en(lane_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .lane_tx(lane_tx),
        .sym_start(sym_start), .underrun(underrun),
`ifdef LANES_SERIALIZER_MC_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .tx_active(tx_active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected serial stream entry: {lane_tx[NL-1:0], sym_start, underrun}.
    task automatic push_sym(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input int len,
                            input bit msb, input logic [NL-1:0] en, input bit ur, input int nbits);
        logic [DW-1:0] w [NL];
        logic [DW-1:0] t;
        logic [NL+1:0] e;
        int idx;
        w[0] = w0;
        w[1] = w1;
        if (ur) exp_ucnt++;
        for (int k = 0; k < nbits; k++) begin
            idx = msb ? (len - 1 - k) : k;
            for (int i = 0; i < NL; i++) begin
                t = w[i] >> idx;
                e[i+2] = en[i] & t[0];
            end
            e[1] = (k == 0);
            e[0] = ur && (k == 0);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst && tx_active) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %b with nothing expected",
                         {lane_tx, sym_start, underrun});
            end else begin
                chk("serial_bit", 32'({lane_tx, sym_start, underrun}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_word(input logic [DW-1:0] w0, input logic [DW-1:0] w1, output int waited);
        waited = 0;
        @(negedge clk);
        in_data  = {w1, w0};
        in_valid = 1'b1;
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready %0b expected 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (exp_q.size() != 0 && n < 2000);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d bits left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle_now(input string tag);
        chk({tag, "_lane_tx"},   32'(lane_tx),   32'd0);
        chk({tag, "_sym_start"}, 32'(sym_start), 32'd0);
        chk({tag, "_underrun"},  32'(underrun),  32'd0);
        chk({tag, "_tx_active"}, 32'(tx_active), 32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        #1;
        idle_now(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // Reset state
        #12;
        idle_now("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 chk("off_in_ready", 32'(in_ready), 32'd0);

        // A: mode 00, MSB-first, 8-bit symbols, then underrun
        gen_speed = 2'b00; lane_en = 2'b11; enable = 1'b1;
        @(negedge clk);
        #1 chk("A_wait_in_ready", 32'(in_ready), 32'd1);
        chk("A_wait_tx_active", 32'(tx_active), 32'd0);
        push_sym(132'hA5, 132'h3C, 8, 1'b1, 2'b11, 1'b0, 8);
        push_sym('0, '0, 8, 1'b1, 2'b11, 1'b1, 8);
        send_word(132'hA5, 132'h3C, w);
        chk("A_wait_latency", 32'(w), 32'd0);
        wait_empty();
        enable = 1'b0;
        check_idle("A_off");

        // B: mode 10, back-to-back words, buffer hold, pop+accept at boundary
        gen_speed = 2'b10; enable = 1'b1;
        push_sym(132'hF_0123_4567_89AB_CDEF_1357, 132'h2_FEDC_BA98_7654_3210, 66, 1'b0, 2'b11, 1'b0, 66);
        push_sym(132'h3_AAAA_5555_F0F0_0F0F, 132'h1_8000_0000_0000_0001, 66, 1'b0, 2'b11, 1'b0, 66);
        push_sym(132'h0_DEAD_BEEF_CAFE_F00D, 132'h3_1111_2222_3333_4444, 66, 1'b0, 2'b11, 1'b0, 66);
        push_sym('0, '0, 66, 1'b0, 2'b11, 1'b1, 66);
        send_word(132'hF_0123_4567_89AB_CDEF_1357, 132'h2_FEDC_BA98_7654_3210, w);
        send_word(132'h3_AAAA_5555_F0F0_0F0F, 132'h1_8000_0000_0000_0001, w);
        chk("B_w1_to_buffer", 32'(w), 32'd0);
        send_word(132'h0_DEAD_BEEF_CAFE_F00D, 132'h3_1111_2222_3333_4444, w);
        chk("B_w2_waits_boundary", 32'(w), 32'd64);
        wait_empty();
        enable = 1'b0;
        check_idle("B_off");

        // C: mode 01, single word then underrun
        gen_speed = 2'b01; enable = 1'b1;
        push_sym(132'h9_0000_0000_FFFF_0000_1234_5678_9ABC_DEF1, 132'hC_3C3C_A5A5_0000_0001, 132, 1'b0, 2'b11, 1'b0, 132);
        push_sym('0, '0, 132, 1'b0, 2'b11, 1'b1, 132);
        send_word(132'h9_0000_0000_FFFF_0000_1234_5678_9ABC_DEF1, 132'hC_3C3C_A5A5_0000_0001, w);
        wait_empty();
        enable = 1'b0;
        check_idle("C_off");
`ifdef LANES_SERIALIZER_MC_UNDERRUN_CNT_EN
        chk("C_underrun_cnt", 32'(underrun_cnt), 32'(exp_ucnt));
`endif

        // D: gen_speed 01 -> 00 mid-symbol takes effect at the next symbol
        gen_speed = 2'b01; enable = 1'b1;
        push_sym(132'h5_5555_0000_AAAA_1234, 132'hA_0F0F_FFFF_0001, 132, 1'b0, 2'b11, 1'b0, 132);
        push_sym(132'hF00_0000_00C3, 132'h7E1, 8, 1'b1, 2'b11, 1'b0, 8);
        push_sym('0, '0, 8, 1'b1, 2'b11, 1'b1, 8);
        send_word(132'h5_5555_0000_AAAA_1234, 132'hA_0F0F_FFFF_0001, w);
        send_word(132'hF00_0000_00C3, 132'h7E1, w);
        repeat (38) @(negedge clk);
        gen_speed = 2'b00;
        wait_empty();
        enable = 1'b0;
        check_idle("D_off");

        // E: lane 0 masked off
        gen_speed = 2'b00; lane_en = 2'b10; enable = 1'b1;
        push_sym(132'hFF, 132'h96, 8, 1'b1, 2'b10, 1'b0, 8);
        push_sym('0, '0, 8, 1'b1, 2'b10, 1'b1, 8);
        send_word(132'hFF, 132'h96, w);
        wait_empty();
        enable = 1'b0;
        check_idle("E_off");
        lane_en = 2'b11;

        // F: enable drop after 20 bits drops the buffered word
        gen_speed = 2'b01; enable = 1'b1;
        push_sym(132'h1_2345_6789_ABCD_EF01, 132'hF_EDCB_A987_6543_210F, 132, 1'b0, 2'b11, 1'b0, 20);
        send_word(132'h1_2345_6789_ABCD_EF01, 132'hF_EDCB_A987_6543_210F, w);
        send_word(132'hFF, 132'hFF, w);
        wait_empty();
        enable = 1'b0;
        check_idle("F_off");
        gen_speed = 2'b00; enable = 1'b1;
        @(negedge clk);
        #1 chk("F_rewait_in_ready", 32'(in_ready), 32'd1);
        chk("F_rewait_tx_active", 32'(tx_active), 32'd0);
        push_sym(132'h81, 132'h42, 8, 1'b1, 2'b11, 1'b0, 8);
        push_sym('0, '0, 8, 1'b1, 2'b11, 1'b1, 8);
        send_word(132'h81, 132'h42, w);
        wait_empty();
        enable = 1'b0;
        check_idle("F_off2");

        // G: asynchronous reset mid-symbol
        gen_speed = 2'b10; enable = 1'b1;
        push_sym(132'h3_FFFF_0000_FFFF_0000, 132'h2_0000_FFFF_0000_FFFF, 66, 1'b0, 2'b11, 1'b0, 30);
        send_word(132'h3_FFFF_0000_FFFF_0000, 132'h2_0000_FFFF_0000_FFFF, w);
        wait_empty();
        rst = 1'b0;
        exp_ucnt = 0;
        #1 idle_now("G_rst");
`ifdef LANES_SERIALIZER_MC_UNDERRUN_CNT_EN
        chk("G_rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        gen_speed = 2'b00;
        @(negedge clk);
        #1 chk("G_rewait_in_ready", 32'(in_ready), 32'd1);
        push_sym(132'h5A, 132'hC3, 8, 1'b1, 2'b11, 1'b0, 8);
        push_sym('0, '0, 8, 1'b1, 2'b11, 1'b1, 8);
        send_word(132'h5A, 132'hC3, w);
        wait_empty();
        enable = 1'b0;
        check_idle("G_off");
`ifdef LANES_SERIALIZER_MC_UNDERRUN_CNT_EN
        chk("G_underrun_cnt", 32'(underrun_cnt), 32'(exp_ucnt));
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
